// File: rtl/wavetable_load_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : wavetable_load_arbiter
//  Purpose  : Shares one wavetable loader between four synth voices. Holds
//             one pending request per voice (latest number wins) and grants
//             them round-robin. Each grant issues a one-cycle load strobe,
//             then waits for the loader's done or a completion timeout.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                 system clock, rising edge
//    rst                 asynchronous active-high reset
//    req_i               per-voice load request pulses
//    req_wtb_num_i       requested wavetable numbers, voice v at [5v+4:5v]
//    ldr_idle_i          loader idle flag
//    ldr_done_i          loader done pulse
//    ldr_done_wtb_num_i  wavetable number the loader reports as completed
//    ldr_wtb_load_o      one-cycle load strobe to the loader
//    ldr_wtb_num_o       wavetable number sent to the loader
//    ldr_voice_num_o     voice index sent to the loader
//    voice_pending_o     voice has a queued, not yet granted request
//    voice_busy_o        voice is pending or currently being loaded
//    voice_done_o        one-cycle pulse on successful completion
//    voice_err_o         one-cycle pulse on mismatch or timeout abort
//    active_wtb_num_o    last successfully loaded wavetable per voice
//    arb_busy_o          arbiter is not idle
// ============================================================================
module wavetable_load_arbiter #(
  parameter int NUM_VOICES = 4,
  parameter int WTB_NUM_W  = 5,
  parameter int TIMEOUT    = 1023,
  parameter int TIMEOUT_W  = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_VOICES-1:0]             req_i,
  input  logic [NUM_VOICES*WTB_NUM_W-1:0]   req_wtb_num_i,
  input  logic                              ldr_idle_i,
  input  logic                              ldr_done_i,
  input  logic [WTB_NUM_W-1:0]              ldr_done_wtb_num_i,
  output logic                              ldr_wtb_load_o,
  output logic [WTB_NUM_W-1:0]              ldr_wtb_num_o,
  output logic [1:0]                        ldr_voice_num_o,
  output logic [NUM_VOICES-1:0]             voice_pending_o,
  output logic [NUM_VOICES-1:0]             voice_busy_o,
  output logic [NUM_VOICES-1:0]             voice_done_o,
  output logic [NUM_VOICES-1:0]             voice_err_o,
  output logic [NUM_VOICES*WTB_NUM_W-1:0]   active_wtb_num_o,
  output logic                              arb_busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                               state_q, state_d;
  logic [NUM_VOICES-1:0]                pend_q, pend_d;
  logic [NUM_VOICES-1:0][WTB_NUM_W-1:0] pend_num_q, pend_num_d;
  logic [1:0]                           ptr_q, ptr_d;
  logic [1:0]                           grant_v_q, grant_v_d;
  logic [WTB_NUM_W-1:0]                 grant_num_q, grant_num_d;
  logic [TIMEOUT_W-1:0]                 tmo_q, tmo_d;
  logic [NUM_VOICES-1:0][WTB_NUM_W-1:0] active_q, active_d;
  logic [NUM_VOICES-1:0]                done_q, done_d;
  logic [NUM_VOICES-1:0]                err_q, err_d;

  // Round-robin winner: first pending voice starting at ptr, wrapping.
  logic       win_found;
  logic [1:0] win_v;
  logic [1:0] cand;

  always_comb begin
    win_found = 1'b0;
    win_v     = ptr_q;
    cand      = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      cand = ptr_q + i[1:0];
      if (!win_found && pend_q[cand]) begin
        win_found = 1'b1;
        win_v     = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_num_d  = pend_num_q;
    ptr_d       = ptr_q;
    grant_v_d   = grant_v_q;
    grant_num_d = grant_num_q;
    tmo_d       = tmo_q;
    active_d    = active_q;
    done_d      = '0;
    err_d       = '0;

    case (state_q)
      ST_IDLE: begin
        // ldr_idle gating also stalls behind a loader that finishes late
        // after a timeout or after an arbiter-only reset.
        if (win_found && ldr_idle_i) begin
          grant_v_d          = win_v;
          grant_num_d        = pend_num_q[win_v];
          pend_d[win_v]      = 1'b0;
          state_d            = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        tmo_d   = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        tmo_d = tmo_q + TIMEOUT_W'(1);
        // done has priority over a timeout in the same cycle
        if (ldr_done_i) begin
          if (ldr_done_wtb_num_i == grant_num_q) begin
            active_d[grant_v_q] = grant_num_q;
            done_d[grant_v_q]   = 1'b1;
          end else begin
            err_d[grant_v_q]    = 1'b1;
          end
          ptr_d   = grant_v_q + 2'd1;
          state_d = ST_IDLE;
        end else if (tmo_q == TIMEOUT_W'(TIMEOUT)) begin
          err_d[grant_v_q] = 1'b1;
          ptr_d            = grant_v_q + 2'd1;
          state_d          = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Capture runs after the grant clear so a request arriving on the grant
    // edge keeps the voice pending with its new number (grant took the old).
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (req_i[v]) begin
        pend_d[v]     = 1'b1;
        pend_num_d[v] = req_wtb_num_i[v*WTB_NUM_W +: WTB_NUM_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pend_q      <= '0;
      pend_num_q  <= '0;
      ptr_q       <= '0;
      grant_v_q   <= '0;
      grant_num_q <= '0;
      tmo_q       <= '0;
      active_q    <= '0;
      done_q      <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_num_q  <= pend_num_d;
      ptr_q       <= ptr_d;
      grant_v_q   <= grant_v_d;
      grant_num_q <= grant_num_d;
      tmo_q       <= tmo_d;
      active_q    <= active_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Loader-facing outputs come straight from state/grant registers; the
  // grant registers only change on a grant, so they hold outside ISSUE.
  assign ldr_wtb_load_o   = (state_q == ST_ISSUE);
  assign ldr_wtb_num_o    = grant_num_q;
  assign ldr_voice_num_o  = grant_v_q;
  assign arb_busy_o       = (state_q != ST_IDLE);
  assign voice_pending_o  = pend_q;
  assign voice_busy_o     = pend_q |
                            ((NUM_VOICES'(1) << grant_v_q) & {NUM_VOICES{arb_busy_o}});
  assign voice_done_o     = done_q;
  assign voice_err_o      = err_q;
  assign active_wtb_num_o = active_q;

endmodule
`default_nettype wire

// File: tb/tb_wavetable_load_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_wavetable_load_arbiter
//  Purpose  : Scoreboard bench for wavetable_load_arbiter with a loader model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wavetable_load_arbiter;

  localparam int TMO = 1023;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [19:0] req_num = '0;
  logic        hold = 1'b1;
  logic        loading = 1'b0;
  logic        ldr_done = 1'b0;
  logic [4:0]  ldr_done_num = '0;
  logic        ldr_idle;

  logic        ldr_wtb_load;
  logic [4:0]  ldr_wtb_num;
  logic [1:0]  ldr_voice_num;
  logic [3:0]  voice_pending, voice_busy, voice_done, voice_err;
  logic [19:0] active;
  logic        arb_busy;

  assign ldr_idle = !hold && !loading;

  always #5 clk = ~clk;

  wavetable_load_arbiter #(
    .NUM_VOICES(4), .WTB_NUM_W(5), .TIMEOUT(TMO), .TIMEOUT_W(10)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .req_i             (req),
    .req_wtb_num_i     (req_num),
    .ldr_idle_i        (ldr_idle),
    .ldr_done_i        (ldr_done),
    .ldr_done_wtb_num_i(ldr_done_num),
    .ldr_wtb_load_o    (ldr_wtb_load),
    .ldr_wtb_num_o     (ldr_wtb_num),
    .ldr_voice_num_o   (ldr_voice_num),
    .voice_pending_o   (voice_pending),
    .voice_busy_o      (voice_busy),
    .voice_done_o      (voice_done),
    .voice_err_o       (voice_err),
    .active_wtb_num_o  (active),
    .arb_busy_o        (arb_busy)
  );

  typedef struct { int v; int num; } strobe_t;
  typedef struct { int v; bit err; logic [19:0] act; int off; } res_t;
  typedef struct { int delay; int dnum; } plan_t;
  typedef struct { logic [3:0] mask; logic [19:0] nums; } reqv_t;

  strobe_t exp_stb[$];
  res_t    exp_res[$];
  plan_t   plans[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_stb_cyc = 0;

  // reference model state
  int          m_ptr = 0;
  logic [19:0] m_active = '0;

  // batch description
  reqv_t      pre[$];
  logic [3:0]  inj_mask[4];
  logic [19:0] inj_nums[4];
  int          force_kind = -1;
  int          force_dnum = -1;
  bit          inj0_release = 1'b0;

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, a, e, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // ---------------- monitor / scoreboard ----------------
  initial begin
    strobe_t es;
    res_t    er;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ldr_wtb_load) begin
          last_stb_cyc = cyc;
          if (exp_stb.size() == 0) check("unexpected_strobe", 1, 0);
          else begin
            es = exp_stb.pop_front();
            check("strobe_voice", 32'(ldr_voice_num), es.v);
            check("strobe_num", 32'(ldr_wtb_num), es.num);
            check("strobe_arb_busy", 32'(arb_busy), 1);
            check("strobe_voice_busy", 32'(voice_busy[es.v]), 1);
          end
        end
        if ((|voice_done) || (|voice_err)) begin
          if (exp_res.size() == 0) check("unexpected_result", 1, 0);
          else begin
            er = exp_res.pop_front();
            check("res_done", 32'(voice_done), er.err ? 0 : (1 << er.v));
            check("res_err", 32'(voice_err), er.err ? (1 << er.v) : 0);
            check("res_active", 32'(active), 32'(er.act));
            check("res_latency", cyc - last_stb_cyc, er.off);
          end
        end
      end
    end
  end

  // ---------------- loader model ----------------
  initial begin
    int    cnt;
    plan_t p;
    cnt = 0;
    p.delay = 3; p.dnum = 0;
    forever begin
      @(posedge clk); #1;
      if (ldr_done) begin
        ldr_done = 1'b0;
        loading  = 1'b0;
      end else if (loading) begin
        if (cnt == 0) begin
          ldr_done     = 1'b1;
          ldr_done_num = p.dnum[4:0];
        end else cnt--;
      end
      if (ldr_wtb_load && !rst) begin
        check("strobe_while_loader_busy", 32'(loading), 0);
        if (plans.size() == 0) begin
          check("missing_plan", 1, 0);
          p.delay = 3; p.dnum = int'(ldr_wtb_num);
        end else p = plans.pop_front();
        loading = 1'b1;
        cnt     = p.delay - 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_stb(input int v, input int num);
    strobe_t s;
    s.v = v; s.num = num;
    exp_stb.push_back(s);
  endtask

  task automatic push_res(input int v, input bit err, input int off);
    res_t r;
    r.v = v; r.err = err; r.act = m_active; r.off = off;
    exp_res.push_back(r);
  endtask

  task automatic push_plan(input int d, input int dn);
    plan_t p;
    p.delay = d; p.dnum = dn;
    plans.push_back(p);
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((exp_res.size() != 0 || exp_stb.size() != 0 || arb_busy || loading) && c < 4*TMO) begin
      @(posedge clk); #1;
      c++;
    end
    check("drain_results_left", exp_res.size(), 0);
    check("drain_strobes_left", exp_stb.size(), 0);
  endtask

  task automatic clear_batch();
    pre.delete();
    for (int i = 0; i < 4; i++) begin inj_mask[i] = '0; inj_nums[i] = '0; end
    force_kind = -1; force_dnum = -1; inj0_release = 1'b0;
  endtask

  // Model: latest request per voice wins; grant order is the first pending
  // voice at or after the pointer; pointer moves past each finished grant.
  task automatic run_batch();
    bit          on[4];
    logic [4:0]  pn[4];
    logic [4:0]  num;
    int w, j, L, kind, d, seen, pend_inj, c, budget;
    for (int v = 0; v < 4; v++) begin on[v] = 0; pn[v] = '0; end
    foreach (pre[k])
      for (int v = 0; v < 4; v++)
        if (pre[k].mask[v]) begin on[v] = 1; pn[v] = pre[k].nums[v*5 +: 5]; end
    j = 0;
    while (on[0] || on[1] || on[2] || on[3]) begin
      w = -1;
      for (int i = 0; i < 4; i++)
        if (w < 0 && on[(m_ptr + i) % 4]) w = (m_ptr + i) % 4;
      num = pn[w];
      push_stb(w, int'(num));
      on[w] = 0;
      if (j < 4)
        for (int v = 0; v < 4; v++)
          if (inj_mask[j][v]) begin on[v] = 1; pn[v] = inj_nums[j][v*5 +: 5]; end
      if (force_kind >= 0) kind = force_kind;
      else begin
        c = int'($urandom_range(0, 99));
        kind = (c < 80) ? 0 : (c < 97) ? 1 : 2;
      end
      d = int'($urandom_range(2, 6));
      if (kind == 0) begin
        push_plan(d, int'(num));
        m_active[w*5 +: 5] = num;
        push_res(w, 1'b0, d + 1);
      end else if (kind == 1) begin
        if (j == 0 && force_dnum >= 0) push_plan(d, force_dnum);
        else push_plan(d, int'(num ^ 5'($urandom_range(1, 31))));
        push_res(w, 1'b1, d + 1);
      end else begin
        push_plan(TMO + 15, int'(num));  // done arrives after the abort
        push_res(w, 1'b1, TMO + 2);
      end
      m_ptr = (w + 1) % 4;
      j++;
    end
    L = j;

    // drive: requests under hold, then release the loader
    foreach (pre[k]) begin
      @(posedge clk); #1;
      req = pre[k].mask; req_num = pre[k].nums;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; req = '0; end
    end
    @(posedge clk); #1;
    req = '0;
    hold = 1'b0;
    if (inj0_release) begin req = inj_mask[0]; req_num = inj_nums[0]; end

    seen = 0; pend_inj = -1; c = 0;
    budget = L * (TMO + 40) + 50;
    while (seen < L && c < budget) begin
      @(posedge clk); #1;
      c++;
      req = '0;
      if (pend_inj >= 0) begin
        req = inj_mask[pend_inj]; req_num = inj_nums[pend_inj]; pend_inj = -1;
      end
      if (ldr_wtb_load) begin
        seen++;
        if (seen <= 4 && !(inj0_release && seen == 1) && inj_mask[seen-1] != 0)
          pend_inj = seen - 1;
      end
    end
    req = '0;
    check("batch_strobe_count", seen, L);
    drain();
    hold = 1'b1;
    clear_batch();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, n0, c;
    logic [3:0] acc;
    reqv_t r;
    clear_batch();

    // reset state
    repeat (2) @(negedge clk);
    check("rst_load", 32'(ldr_wtb_load), 0);
    check("rst_done", 32'(voice_done), 0);
    check("rst_err", 32'(voice_err), 0);
    check("rst_arb_busy", 32'(arb_busy), 0);
    check("rst_active", 32'(active), 0);
    check("rst_pending", 32'(voice_pending), 0);
    check("rst_busy", 32'(voice_busy), 0);
    check("rst_ldr_num", 32'(ldr_wtb_num), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single request latency, voice 0 num 7
    hold = 1'b0;
    push_stb(0, 7); push_plan(3, 7);
    m_active[4:0] = 5'd7; push_res(0, 1'b0, 4); m_ptr = 1;
    @(posedge clk); #1; req = 4'b0001; req_num = 20'd7;
    @(posedge clk); #1; req = '0;
    check("latency_c1", 32'(ldr_wtb_load), 0);
    @(posedge clk); #1;
    check("latency_c2", 32'(ldr_wtb_load), 1);
    drain();
    hold = 1'b1;

    // all four voices, then voices 0 and 3
    force_kind = 0;
    r.mask = 4'b1111; r.nums = {5'd4, 5'd3, 5'd2, 5'd1}; pre.push_back(r);
    run_batch();
    force_kind = 0;
    r.mask = 4'b1001; r.nums = {5'd30, 5'd0, 5'd0, 5'd29}; pre.push_back(r);
    run_batch();

    // overwrite before grant: only num 9 is loaded for voice 2
    force_kind = 0;
    r.mask = 4'b0100; r.nums = 20'(5) << 10; pre.push_back(r);
    r.mask = 4'b0100; r.nums = 20'(9) << 10; pre.push_back(r);
    run_batch();

    // request on the voice in flight is queued
    force_kind = 0;
    r.mask = 4'b0010; r.nums = 20'(8) << 5; pre.push_back(r);
    inj_mask[0] = 4'b0010; inj_nums[0] = 20'(12) << 5;
    run_batch();

    // request on the grant edge: old number granted, new one stays pending
    force_kind = 0;
    r.mask = 4'b0001; r.nums = 20'd20; pre.push_back(r);
    inj0_release = 1'b1; inj_mask[0] = 4'b0001; inj_nums[0] = 20'd21;
    run_batch();

    // timeout with the loader never finishing in time
    force_kind = 2;
    r.mask = 4'b0100; r.nums = 20'(6) << 10; pre.push_back(r);
    run_batch();

    // done number mismatch: 3 reported for grant 4
    force_kind = 1; force_dnum = 3;
    r.mask = 4'b1000; r.nums = 20'(4) << 15; pre.push_back(r);
    run_batch();

    // reset during WAIT_DONE; next grant must wait for the loader
    hold = 1'b0;
    push_stb(0, 17); push_plan(40, 17);
    @(posedge clk); #1; req = 4'b0001; req_num = 20'd17;
    @(posedge clk); #1; req = '0;
    c = 0;
    while (!ldr_wtb_load && c < 10) begin @(posedge clk); #1; c++; end
    check("rst_test_strobe_seen", 32'(ldr_wtb_load), 1);
    repeat (4) @(posedge clk);
    #1; req = 4'b1000; req_num = 20'(22) << 15;
    @(posedge clk); #1; req = '0;
    @(negedge clk); #2; rst = 1'b1;
    #1;
    check("midrst_arb_busy", 32'(arb_busy), 0);
    check("midrst_pending", 32'(voice_pending), 0);
    check("midrst_busy", 32'(voice_busy), 0);
    check("midrst_active", 32'(active), 0);
    check("midrst_ldr_num", 32'(ldr_wtb_num), 0);
    check("midrst_ldr_voice", 32'(ldr_voice_num), 0);
    check("midrst_load", 32'(ldr_wtb_load), 0);
    @(posedge clk); #1; rst = 1'b0;
    m_ptr = 0; m_active = '0;
    push_stb(2, 11); push_plan(3, 11);
    m_active[14:10] = 5'd11; push_res(2, 1'b0, 4); m_ptr = 3;
    req = 4'b0100; req_num = 20'(11) << 10;
    @(posedge clk); #1; req = '0;
    check("post_rst_held", 32'(loading & ~ldr_wtb_load), 1);
    drain();
    hold = 1'b1;

    // randomized batches
    for (int b = 0; b < 30; b++) begin
      n = int'($urandom_range(1, 4));
      acc = '0;
      for (int k = 0; k < n; k++) begin
        r.mask = 4'($urandom_range(1, 15));
        r.nums = 20'($urandom);
        acc |= r.mask;
        pre.push_back(r);
      end
      n0 = 0;
      for (int v = 0; v < 4; v++) if (acc[v]) n0++;
      for (int k = 0; k < n0; k++)
        if ($urandom_range(0, 9) < 3) begin
          inj_mask[k] = 4'($urandom_range(1, 15));
          inj_nums[k] = 20'($urandom);
        end
      run_batch();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
